// File: rtl/ppg_pkg.sv
// Shared constants for the PPG vitals smoother: state encoding and plausibility limits.
package ppg_pkg;

    localparam logic [1:0] ST_NO_FINGER = 2'd0;
    localparam logic [1:0] ST_ACQUIRE   = 2'd1;
    localparam logic [1:0] ST_TRACK     = 2'd2;
    localparam logic [1:0] ST_LOST      = 2'd3;

    localparam int HR_MIN       = 40;
    localparam int HR_MAX       = 200;
    localparam int SPO2_MIN     = 70;
    localparam int SPO2_MAX     = 100;
    localparam int REJECT_LIMIT = 3;

    function automatic logic is_plausible(input logic [7:0] bpm, input logic [7:0] spo2);
        return (bpm >= 8'(HR_MIN)) && (bpm <= 8'(HR_MAX)) &&
               (spo2 >= 8'(SPO2_MIN)) && (spo2 <= 8'(SPO2_MAX));
    endfunction

endpackage

// File: rtl/ppg_ring_avg.sv
// 8-bit ring buffer with running sum and registered average; flush empties the
// buffer, clear additionally zeroes the published average.
module ppg_ring_avg #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       clear,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       emit,
    output logic [7:0] avg,
    output logic       valid
);
    import ppg_pkg::*;

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SW    = 8 + DEPTH_LOG2;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [SW-1:0]         sum;
    logic                  emit_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            sum    <= '0;
            emit_q <= 1'b0;
            avg    <= '0;
            valid  <= 1'b0;
        end else begin
            valid  <= 1'b0;
            emit_q <= emit & ~clear;
            // A flush may carry a write: that beat becomes entry 0 of the new buffer.
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
                if (wr_en) begin
                    mem[0] <= wr_data;
                    sum    <= SW'(wr_data);
                    wr_ptr <= DEPTH_LOG2'(1);
                end else begin
                    sum    <= '0;
                    wr_ptr <= '0;
                end
            end else if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                sum         <= sum + SW'(wr_data) - SW'(mem[wr_ptr]);
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (clear) begin
                avg <= '0;
            end else if (emit_q) begin
                avg   <= 8'(sum >> DEPTH_LOG2);
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ppg_vitals_smoother.sv
// Finger-presence FSM, beat qualification and moving-average HR/SpO2 reporting.
// Optional PPG_OUTLIER_REJECT_EN enables the TRACK jump check and reject flush.
module ppg_vitals_smoother #(
    parameter int                  DC_WIDTH        = 18,
    parameter int                  DEPTH_LOG2      = 3,
    parameter logic [DC_WIDTH-1:0] DC_MIN          = 18'd50000,
    parameter int                  TIMEOUT_SAMPLES = 400,
    parameter int                  MAX_JUMP        = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_sample_valid,
    input  logic [DC_WIDTH-1:0] i_dc_level,
    input  logic                i_beat_pulse,
    input  logic [7:0]          i_bpm,
    input  logic [7:0]          i_spo2,
    output logic [7:0]          o_hr,
    output logic [7:0]          o_spo2,
    output logic [1:0]          o_state,
    output logic                o_finger_on,
    output logic                o_valid
);
    import ppg_pkg::*;

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = $clog2(TIMEOUT_SAMPLES + 1);
    localparam int FW    = DEPTH_LOG2 + 1;

    logic [1:0]    state_q, state_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          finger_lost, finger_seen, plausible, tmo_expire, accept_ok;
    logic          wr_en, flush, clear, emit;
    logic [7:0]    diff;
    logic          hr_valid, spo2_valid;

    assign finger_lost = i_sample_valid && (i_dc_level < DC_MIN);
    assign finger_seen = i_sample_valid && (i_dc_level >= DC_MIN);
    assign plausible   = i_beat_pulse && is_plausible(i_bpm, i_spo2) && !finger_lost;
    assign tmo_expire  = i_sample_valid && (tmo_q == TW'(1));
    assign diff        = (i_bpm >= o_hr) ? (i_bpm - o_hr) : (o_hr - i_bpm);

`ifdef PPG_OUTLIER_REJECT_EN
    logic [1:0] rej_q, rej_d;
    assign accept_ok = (int'(diff) <= MAX_JUMP);
`else
    assign accept_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        tmo_d   = tmo_q;
        wr_en   = 1'b0;
        flush   = 1'b0;
        clear   = 1'b0;
        emit    = 1'b0;
`ifdef PPG_OUTLIER_REJECT_EN
        rej_d   = rej_q;
`endif
        if ((state_q == ST_ACQUIRE || state_q == ST_TRACK) && i_sample_valid && tmo_q != '0)
            tmo_d = tmo_q - 1'b1;
        case (state_q)
            ST_NO_FINGER: begin
                flush  = 1'b1;
                clear  = 1'b1;
                fill_d = '0;
                if (finger_seen) begin
                    state_d = ST_ACQUIRE;
                    tmo_d   = TW'(TIMEOUT_SAMPLES);
                end
            end
            ST_ACQUIRE: begin
                if (plausible) begin
                    wr_en  = 1'b1;
                    tmo_d  = TW'(TIMEOUT_SAMPLES);
                    fill_d = fill_q + 1'b1;
                    if (fill_q == FW'(DEPTH - 1)) begin
                        state_d = ST_TRACK;
                        emit    = 1'b1;
                    end
                end else if (tmo_expire) begin
                    state_d = ST_LOST;
                end
            end
            ST_TRACK: begin
                if (plausible && accept_ok) begin
                    wr_en = 1'b1;
                    emit  = 1'b1;
                    tmo_d = TW'(TIMEOUT_SAMPLES);
`ifdef PPG_OUTLIER_REJECT_EN
                    rej_d = '0;
`endif
                end else begin
`ifdef PPG_OUTLIER_REJECT_EN
                    if (plausible) begin
                        if (rej_q == 2'(REJECT_LIMIT - 1)) begin
                            state_d = ST_ACQUIRE;
                            flush   = 1'b1;
                            fill_d  = '0;
                            rej_d   = '0;
                        end else begin
                            rej_d = rej_q + 1'b1;
                        end
                    end
`endif
                    if (tmo_expire) state_d = ST_LOST;
                end
            end
            default: begin
                if (plausible) begin
                    state_d = ST_ACQUIRE;
                    flush   = 1'b1;
                    wr_en   = 1'b1;
                    fill_d  = FW'(1);
                    tmo_d   = TW'(TIMEOUT_SAMPLES);
                end
            end
        endcase
        // Finger removal overrides everything, including a beat in the same cycle.
        if (finger_lost) begin
            state_d = ST_NO_FINGER;
            wr_en   = 1'b0;
            emit    = 1'b0;
            flush   = 1'b1;
            clear   = 1'b1;
            fill_d  = '0;
            tmo_d   = '0;
        end
`ifdef PPG_OUTLIER_REJECT_EN
        if (finger_lost || state_q == ST_NO_FINGER || state_q == ST_LOST) rej_d = '0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_NO_FINGER;
            fill_q      <= '0;
            tmo_q       <= '0;
            o_finger_on <= 1'b0;
`ifdef PPG_OUTLIER_REJECT_EN
            rej_q       <= '0;
`endif
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            tmo_q   <= tmo_d;
            if (i_sample_valid) o_finger_on <= finger_seen;
`ifdef PPG_OUTLIER_REJECT_EN
            rej_q   <= rej_d;
`endif
        end
    end

    ppg_ring_avg #(.DEPTH_LOG2(DEPTH_LOG2)) u_bpm_avg (
        .clk(clk), .rst(rst), .flush(flush), .clear(clear), .wr_en(wr_en),
        .wr_data(i_bpm), .emit(emit), .avg(o_hr), .valid(hr_valid)
    );

    ppg_ring_avg #(.DEPTH_LOG2(DEPTH_LOG2)) u_spo2_avg (
        .clk(clk), .rst(rst), .flush(flush), .clear(clear), .wr_en(wr_en),
        .wr_data(i_spo2), .emit(emit), .avg(o_spo2), .valid(spo2_valid)
    );

    assign o_state = state_q;
    assign o_valid = hr_valid & spo2_valid;

endmodule

// File: tb/tb_ppg_vitals_smoother.sv
// Scoreboard bench for ppg_vitals_smoother: directed beats push expected
// averages, a negedge monitor pops and compares on every o_valid.
module tb_ppg_vitals_smoother;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_sample_valid;
    logic [17:0] i_dc_level;
    logic        i_beat_pulse;
    logic [7:0]  i_bpm;
    logic [7:0]  i_spo2;
    logic [7:0]  o_hr;
    logic [7:0]  o_spo2;
    logic [1:0]  o_state;
    logic        o_finger_on;
    logic        o_valid;

    typedef struct {
        logic [7:0] hr;
        logic [7:0] spo2;
        int         due;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    ppg_vitals_smoother dut (
        .clk(clk), .rst(rst), .i_sample_valid(i_sample_valid), .i_dc_level(i_dc_level),
        .i_beat_pulse(i_beat_pulse), .i_bpm(i_bpm), .i_spo2(i_spo2),
        .o_hr(o_hr), .o_spo2(o_spo2), .o_state(o_state), .o_finger_on(o_finger_on),
        .o_valid(o_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due < cyc) begin
            checks++;
            failures++;
            $display("FAIL missing_valid expected at cycle %0d, now %0d", q[0].due, cyc);
            void'(q.pop_front());
        end
        if (o_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid hr=%0d spo2=%0d cycle=%0d", o_hr, o_spo2, cyc);
            end else begin
                e = q.pop_front();
                if (o_hr !== e.hr || o_spo2 !== e.spo2 || cyc != e.due) begin
                    failures++;
                    $display("FAIL valid_data got hr=%0d spo2=%0d cycle=%0d, want hr=%0d spo2=%0d cycle=%0d",
                             o_hr, o_spo2, cyc, e.hr, e.spo2, e.due);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic strobe(input logic sv, input logic [17:0] dc, input logic bp,
                          input logic [7:0] bpm, input logic [7:0] spo2,
                          input logic push, input logic [7:0] ehr, input logic [7:0] esp);
        @(negedge clk);
        i_sample_valid = sv;
        i_dc_level     = dc;
        i_beat_pulse   = bp;
        i_bpm          = bpm;
        i_spo2         = spo2;
        if (push) q.push_back('{hr: ehr, spo2: esp, due: cyc + 2});
        @(negedge clk);
        i_sample_valid = 1'b0;
        i_beat_pulse   = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic sample(input logic [17:0] dc);
        strobe(1'b1, dc, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
    endtask

    task automatic beat(input logic [7:0] bpm, input logic [7:0] spo2,
                        input logic push, input logic [7:0] ehr, input logic [7:0] esp);
        strobe(1'b0, 18'd60000, 1'b1, bpm, spo2, push, ehr, esp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic refill72();
        sample(18'd60000);
        repeat (7) beat(8'd72, 8'd98, 1'b0, 8'd0, 8'd0);
        beat(8'd72, 8'd98, 1'b1, 8'd72, 8'd98);
    endtask

    initial begin
        rst = 1'b1;
        i_sample_valid = 1'b0;
        i_dc_level = '0;
        i_beat_pulse = 1'b0;
        i_bpm = '0;
        i_spo2 = '0;
        repeat (3) @(negedge clk);
        check("reset_hr", o_hr, 0);
        check("reset_state", o_state, 0);
        check("reset_finger", o_finger_on, 0);
        check("reset_valid", o_valid, 0);
        rst = 1'b0;
        @(negedge clk);

        // Finger detect, fill with implausible beats mixed in
        sample(18'd60000);
        check("finger_on", o_finger_on, 1);
        check("acquire_state", o_state, 1);
        check("acquire_hr", o_hr, 0);
        repeat (7) beat(8'd72, 8'd98, 1'b0, 8'd0, 8'd0);
        beat(8'd30, 8'd98, 1'b0, 8'd0, 8'd0);
        beat(8'd72, 8'd60, 1'b0, 8'd0, 8'd0);
        check("still_acquire", o_state, 1);
        beat(8'd72, 8'd98, 1'b1, 8'd72, 8'd98);
        check("track_state", o_state, 2);
        beat(8'd80, 8'd98, 1'b1, 8'd73, 8'd98);
        beat(8'd30, 8'd98, 1'b0, 8'd0, 8'd0);
        check("hr_after_80", o_hr, 73);

        // Reset mid-TRACK
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_hr", o_hr, 0);
        check("midrst_spo2", o_spo2, 0);
        check("midrst_state", o_state, 0);
        check("midrst_finger", o_finger_on, 0);
        check("midrst_valid", o_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        refill72();

        // Outlier beats
`ifdef PPG_OUTLIER_REJECT_EN
        beat(8'd130, 8'd98, 1'b0, 8'd0, 8'd0);
        beat(8'd130, 8'd98, 1'b0, 8'd0, 8'd0);
        check("reject2_state", o_state, 2);
        beat(8'd130, 8'd98, 1'b0, 8'd0, 8'd0);
        check("reject3_state", o_state, 1);
        repeat (7) beat(8'd72, 8'd98, 1'b0, 8'd0, 8'd0);
        check("reflush_acquire", o_state, 1);
        beat(8'd72, 8'd98, 1'b1, 8'd72, 8'd98);
        check("reflush_track", o_state, 2);
`else
        beat(8'd130, 8'd98, 1'b1, 8'd79, 8'd98);
        beat(8'd130, 8'd98, 1'b1, 8'd86, 8'd98);
        beat(8'd130, 8'd98, 1'b1, 8'd93, 8'd98);
        check("noreject_state", o_state, 2);
`endif
        do_reset();
        refill72();

        // Timeout
        repeat (399) sample(18'd60000);
        check("pre_timeout_state", o_state, 2);
        sample(18'd60000);
        check("lost_state", o_state, 3);
        check("lost_hr_held", o_hr, 72);
        beat(8'd201, 8'd98, 1'b0, 8'd0, 8'd0);
        check("lost_ignores_201", o_state, 3);
        beat(8'd75, 8'd98, 1'b0, 8'd0, 8'd0);
        check("lost_to_acquire", o_state, 1);
        repeat (6) beat(8'd75, 8'd98, 1'b0, 8'd0, 8'd0);
        check("fill_7_acquire", o_state, 1);
        beat(8'd75, 8'd98, 1'b1, 8'd75, 8'd98);
        check("fill_8_track", o_state, 2);

        // Finger removal coinciding with a beat
        strobe(1'b1, 18'd1000, 1'b1, 8'd75, 8'd98, 1'b0, 8'd0, 8'd0);
        check("removal_state", o_state, 0);
        check("removal_hr", o_hr, 0);
        check("removal_spo2", o_spo2, 0);
        check("removal_finger", o_finger_on, 0);

        repeat (5) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
